deser_param: RTL and testbench

//  Parametrised serial-to-parallel converter. Next generation of the fixed 16-bit deserializer.

---
 rtl/deser_pkg.sv | 15 +
 rtl/deser_bit_cnt.sv | 36 +++
 rtl/deser_param.sv | 83 ++++++++
 tb/tb_deser_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the parametrised deserializer.
// Holds the bit-order enum and the derivation of the count/mod width.
package deser_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  // Wide enough to hold the values 0..w, because mod can equal the full width.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/deser_bit_cnt.sv
// Bit position counter for the deserializer.
// Counts 0..DATA_W-1, wraps at the top, and can be cleared early on a flush.
module deser_bit_cnt
  import deser_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int CNT_W  = cnt_w(DATA_W)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_pos_o
);

  localparam logic [CNT_W-1:0] TOP_POS = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      if (r_cnt == TOP_POS) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt_o      = r_cnt;
  assign last_pos_o = (r_cnt == TOP_POS);

endmodule

// File: rtl/deser_param.sv
// Parametrised serial-to-parallel converter with selectable bit order.
// A partial word is flushed by data_last_i; deser_data_mod_o reports how many bits are valid.
module deser_param
  import deser_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CNT_W     = cnt_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              data_last_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o
);

  localparam bit_order_e       ORDER   = bit_order_e'(MSB_FIRST);
  localparam logic [CNT_W-1:0] TOP_POS = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  w_cnt;
  logic              w_last_pos;
  logic              w_done;
  logic              w_flush;
  logic [CNT_W-1:0]  w_pos;
  logic [DATA_W-1:0] w_word;

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_mod;
  logic              r_val;

  // A flush clears the counter; a full word wraps it, so both restart at bit 0.
  assign w_flush = data_val_i && data_last_i;
  assign w_done  = data_val_i && (w_last_pos || data_last_i);

  deser_bit_cnt #(
    .DATA_W (DATA_W)
  ) u_bit_cnt (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .inc_i      (data_val_i),
    .clr_i      (w_flush),
    .cnt_o      (w_cnt),
    .last_pos_o (w_last_pos)
  );

  // Bits are written in place rather than shifted, so partial words come out
  // right-aligned for LSB-first and left-aligned for MSB-first with zero fill.
  always_comb begin
    w_pos = (ORDER == deser_pkg::MSB_FIRST) ? (TOP_POS - w_cnt) : w_cnt;
    w_word = r_shift;
    w_word[w_pos] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_shift <= '0;
      r_data  <= '0;
      r_mod   <= '0;
      r_val   <= 1'b0;
    end else begin
      r_val <= 1'b0;
      if (data_val_i) begin
        if (w_done) begin
          r_data  <= w_word;
          r_mod   <= w_cnt + CNT_W'(1);
          r_val   <= 1'b1;
          r_shift <= '0;
        end else begin
          r_shift <= w_word;
        end
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;

endmodule

// File: tb/tb_deser_param.sv
// Self-checking bench for deser_param: three instances (16/LSB, 8/MSB, 16/MSB)
// driven by directed vectors, with per-instance expected queues and a negedge monitor.
module tb_deser_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_in[3];
  logic        v_in[3];
  logic        l_in[3];
  logic        r_in[3];
  logic        rst_q[3];
  logic [15:0] o_data[3];
  logic [4:0]  o_mod[3];
  logic        o_val[3];

  logic [15:0] o_data0, o_data2;
  logic [4:0]  o_mod0, o_mod2;
  logic [7:0]  o_data1;
  logic [3:0]  o_mod1;
  logic        o_val0, o_val1, o_val2;

  logic [31:0] cyc = 32'd0;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Entry layout: {pulse cycle[31:0], mod[4:0], data[15:0]}
  logic [52:0] exp_q0[$];
  logic [52:0] exp_q1[$];
  logic [52:0] exp_q2[$];
  logic [15:0] hold_d[3];
  logic [4:0]  hold_m[3];

  deser_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u_dut0 (
    .clk_i(clk), .srst_i(r_in[0]), .data_i(d_in[0]), .data_val_i(v_in[0]),
    .data_last_i(l_in[0]), .deser_data_o(o_data0), .deser_data_mod_o(o_mod0),
    .deser_data_val_o(o_val0));

  deser_param #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut1 (
    .clk_i(clk), .srst_i(r_in[1]), .data_i(d_in[1]), .data_val_i(v_in[1]),
    .data_last_i(l_in[1]), .deser_data_o(o_data1), .deser_data_mod_o(o_mod1),
    .deser_data_val_o(o_val1));

  deser_param #(.DATA_W(16), .MSB_FIRST(1'b1)) u_dut2 (
    .clk_i(clk), .srst_i(r_in[2]), .data_i(d_in[2]), .data_val_i(v_in[2]),
    .data_last_i(l_in[2]), .deser_data_o(o_data2), .deser_data_mod_o(o_mod2),
    .deser_data_val_o(o_val2));

  assign o_data[0] = o_data0;
  assign o_data[1] = {8'h00, o_data1};
  assign o_data[2] = o_data2;
  assign o_mod[0]  = o_mod0;
  assign o_mod[1]  = {1'b0, o_mod1};
  assign o_mod[2]  = o_mod2;
  assign o_val[0]  = o_val0;
  assign o_val[1]  = o_val1;
  assign o_val[2]  = o_val2;

  // ---------------- clock/reset bookkeeping ----------------
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    for (int s = 0; s < 3; s++) rst_q[s] <= r_in[s];
  end

  // ---------------- scoreboard queues ----------------
  task automatic q_push(input int s, input logic [52:0] e);
    case (s)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int s);
    case (s)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic q_pop(input int s, output logic [52:0] e);
    case (s)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  // ---------------- monitor ----------------
  task automatic check_dut(input int s);
    logic [52:0] e;
    if (rst_q[s]) begin
      hold_d[s] = 16'h0;
      hold_m[s] = 5'd0;
      checks++;
      if (o_val[s] !== 1'b0 || o_data[s] !== 16'h0 || o_mod[s] !== 5'd0) begin
        failures++;
        $display("FAIL rst_clear dut%0d: val=%0b data=%h mod=%0d, required 0/0/0",
                 s, o_val[s], o_data[s], o_mod[s]);
      end
    end else if (o_val[s] === 1'b1) begin
      checks++;
      if (q_size(s) == 0) begin
        failures++;
        $display("FAIL unexpected_pulse dut%0d cyc=%0d: data=%h mod=%0d, required no pulse",
                 s, cyc, o_data[s], o_mod[s]);
      end else begin
        q_pop(s, e);
        if (o_data[s] !== e[15:0] || o_mod[s] !== e[20:16] || cyc !== e[52:21]) begin
          failures++;
          $display("FAIL pulse dut%0d: data=%h mod=%0d cyc=%0d, required data=%h mod=%0d cyc=%0d",
                   s, o_data[s], o_mod[s], cyc, e[15:0], e[20:16], e[52:21]);
        end
        hold_d[s] = e[15:0];
        hold_m[s] = e[20:16];
      end
    end else begin
      checks++;
      if (o_val[s] !== 1'b0 || o_data[s] !== hold_d[s] || o_mod[s] !== hold_m[s]) begin
        failures++;
        $display("FAIL hold dut%0d cyc=%0d: val=%b data=%h mod=%0d, required val=0 data=%h mod=%0d",
                 s, cyc, o_val[s], o_data[s], o_mod[s], hold_d[s], hold_m[s]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int s = 0; s < 3; s++) check_dut(s);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input logic b, input logic v, input logic l);
    d_in[s] = b;
    v_in[s] = v;
    l_in[s] = l;
    @(posedge clk);
    #1;
    v_in[s] = 1'b0;
    l_in[s] = 1'b0;
  endtask

  task automatic pulse_rst(input int s);
    r_in[s] = 1'b1;
    @(posedge clk);
    #1;
    r_in[s] = 1'b0;
  endtask

  // bits[k] is the k-th bit on the wire; the expected word is supplied by the caller.
  task automatic send_bits(input int s, input logic [15:0] bits, input int n,
                           input logic last, input int max_gap, input logic exp_en,
                           input logic [15:0] exp_data, input logic [4:0] exp_mod);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) drive(s, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (k == n - 1 && exp_en) q_push(s, {cyc + 32'd1, exp_mod, exp_data});
      drive(s, bits[k], 1'b1, last && (k == n - 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int s = 0; s < 3; s++) begin
      d_in[s] = 1'b0; v_in[s] = 1'b0; l_in[s] = 1'b0; r_in[s] = 1'b1;
      hold_d[s] = 16'h0; hold_m[s] = 5'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (o_val[s] !== 1'b0 || o_data[s] !== 16'h0 || o_mod[s] !== 5'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: val=%b data=%h mod=%0d, required 0/0/0",
                 s, o_val[s], o_data[s], o_mod[s]);
      end
      r_in[s] = 1'b0;
    end
    @(negedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // full LSB-first word
    send_bits(0, 16'hA5C3, 16, 1'b0, 0, 1'b1, 16'hA5C3, 5'd16);
    // MSB-first width 8: 1,0,1,1,0,0,1,0 and a 3-bit flush 1,1,0
    send_bits(1, 16'h004D, 8, 1'b0, 0, 1'b1, 16'h00B2, 5'd8);
    send_bits(1, 16'h0003, 3, 1'b1, 0, 1'b1, 16'h00C0, 5'd3);
    // early flush 1,1,0,1 in both orders, then a full MSB-first word
    send_bits(0, 16'h000B, 4, 1'b1, 0, 1'b1, 16'h000B, 5'd4);
    send_bits(2, 16'h000B, 4, 1'b1, 0, 1'b1, 16'hD000, 5'd4);
    send_bits(2, 16'hC3A5, 16, 1'b0, 0, 1'b1, 16'hA5C3, 5'd16);
    // gapped word, then two words back-to-back
    send_bits(0, 16'h1234, 16, 1'b0, 5, 1'b1, 16'h1234, 5'd16);
    send_bits(0, 16'hBEEF, 16, 1'b0, 0, 1'b1, 16'hBEEF, 5'd16);
    send_bits(0, 16'h0F0F, 16, 1'b0, 0, 1'b1, 16'h0F0F, 5'd16);
    repeat (3) drive(0, 1'b0, 1'b0, 1'b0);
    // reset mid-word discards the 7 collected bits
    send_bits(0, 16'h007F, 7, 1'b0, 0, 1'b0, 16'h0, 5'd0);
    pulse_rst(0);
    send_bits(0, 16'hFFFF, 16, 1'b0, 0, 1'b1, 16'hFFFF, 5'd16);
    // last without valid is ignored
    repeat (3) drive(0, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1, 1'b1, 1'b0, 1'b1);
    // last on the final bit gives a single full-word pulse
    send_bits(0, 16'h8001, 16, 1'b1, 0, 1'b1, 16'h8001, 5'd16);
    // last on bit 0
    send_bits(0, 16'h0001, 1, 1'b1, 0, 1'b1, 16'h0001, 5'd1);
    send_bits(2, 16'h0001, 1, 1'b1, 0, 1'b1, 16'h8000, 5'd1);
    repeat (5) drive(0, 1'b0, 1'b0, 1'b0);

    for (int s = 0; s < 3; s++) begin
      checks++;
      if (q_size(s) != 0) begin
        failures++;
        $display("FAIL missing_pulse dut%0d: %0d pulses outstanding, required 0", s, q_size(s));
      end
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
